// File: rtl/toggle_bank_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : toggle_bank_arbiter
// Purpose  : Arbitrates NREQ requesters onto one shared bank of WIDTH toggle
//            flip-flops. Each granted transaction goes through three states.
//            In IDLE a winner is picked and its mask slice is latched. In
//            TOGGLE the bank is updated with Q ^= mask. In DONE a done pulse
//            is issued.
//
//            Build option TOGGLE_BANK_ARBITER_RR_EN:
//              defined   -> round-robin arbitration starting at a pointer
//                           that moves to (winner+1) mod NREQ after DONE.
//              undefined -> fixed priority, where the lowest index wins.
//
// Ports    : Clk   in   rising-edge clock
//            rst   in   asynchronous, active-low reset
//            req   in   [NREQ]        per-requester level request
//            mask  in   [NREQ*WIDTH]  slice i = mask[i*WIDTH +: WIDTH]
//            gnt   out  [NREQ]        one-hot grant, held for the transaction
//            done  out  [NREQ]        one-cycle completion pulse
//            Q     out  [WIDTH]       toggle bank state
//            Q_b   out  [WIDTH]       ~Q
//            busy  out                high whenever the FSM is not in IDLE
//
// Revision : 1.0 - initial release
// ============================================================================
module toggle_bank_arbiter #(
   parameter int NREQ  = 4,
   parameter int WIDTH = 8
) (
   input  logic                  Clk,
   input  logic                  rst,
   input  logic [NREQ-1:0]       req,
   input  logic [NREQ*WIDTH-1:0] mask,
   output logic [NREQ-1:0]       gnt,
   output logic [NREQ-1:0]       done,
   output logic [WIDTH-1:0]      Q,
   output logic [WIDTH-1:0]      Q_b,
   output logic                  busy
);

   localparam int c_IW = (NREQ > 1) ? $clog2(NREQ) : 1;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_TOGGLE = 2'd1,
      S_DONE   = 2'd2
   } state_t;

   state_t            r_state;
   state_t            w_state_nxt;
   logic [NREQ-1:0]   r_gnt;
   logic [NREQ-1:0]   w_gnt_nxt;
   logic [NREQ-1:0]   r_done;
   logic [NREQ-1:0]   w_done_nxt;
   logic [WIDTH-1:0]  r_q;
   logic [WIDTH-1:0]  w_q_nxt;
   logic [WIDTH-1:0]  r_mask;
   logic [WIDTH-1:0]  w_mask_nxt;

   logic              w_win_vld;
   logic [c_IW-1:0]   w_win_idx;
   logic [c_IW-1:0]   w_cand;
   logic [NREQ-1:0]   w_win_oh;
   logic [WIDTH-1:0]  w_slice [NREQ];

`ifdef TOGGLE_BANK_ARBITER_RR_EN
   logic [c_IW-1:0]   r_ptr;
   logic [c_IW-1:0]   w_ptr_nxt;
   logic [c_IW-1:0]   r_idx;
   logic [c_IW-1:0]   w_idx_nxt;
`endif

   // ------------------------------------------------------------------------
   // Break the flat mask bus into per-requester slices.
   // ------------------------------------------------------------------------
   for (genvar g = 0; g < NREQ; g++) begin : g_slice
      assign w_slice[g] = mask[g*WIDTH +: WIDTH];
   end

   // ------------------------------------------------------------------------
   // Winner selection. The candidate order begins at the pointer
   // (round-robin) or at index 0 (fixed priority). The first requester that
   // is asserting req wins.
   // ------------------------------------------------------------------------
   always_comb begin
      w_win_vld = 1'b0;
      w_win_idx = '0;
      w_cand    = '0;
      for (int k = 0; k < NREQ; k++) begin
`ifdef TOGGLE_BANK_ARBITER_RR_EN
         w_cand = c_IW'((int'(r_ptr) + k) % NREQ);
`else
         w_cand = c_IW'(k);
`endif
         if (!w_win_vld && req[w_cand]) begin
            w_win_vld = 1'b1;
            w_win_idx = w_cand;
         end
      end
   end

   assign w_win_oh = {{(NREQ-1){1'b0}}, 1'b1} << w_win_idx;

   // ------------------------------------------------------------------------
   // FSM state register
   // ------------------------------------------------------------------------
   always_ff @(posedge Clk or negedge rst) begin
      if (!rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // ------------------------------------------------------------------------
   // FSM next-state and datapath next values
   // ------------------------------------------------------------------------
   always_comb begin
      w_state_nxt = r_state;
      w_gnt_nxt   = r_gnt;
      w_done_nxt  = '0;
      w_q_nxt     = r_q;
      w_mask_nxt  = r_mask;
`ifdef TOGGLE_BANK_ARBITER_RR_EN
      w_ptr_nxt   = r_ptr;
      w_idx_nxt   = r_idx;
`endif
      case (r_state)
         S_IDLE: begin
            if (w_win_vld) begin
               w_state_nxt = S_TOGGLE;
               w_gnt_nxt   = w_win_oh;
               // Latch the mask here so that later changes on the bus cannot
               // affect the toggle.
               w_mask_nxt  = w_slice[w_win_idx];
`ifdef TOGGLE_BANK_ARBITER_RR_EN
               w_idx_nxt   = w_win_idx;
`endif
            end
         end
         S_TOGGLE: begin
            w_state_nxt = S_DONE;
            w_q_nxt     = r_q ^ r_mask;
            // Grant is one-hot, so it already selects the done bit.
            w_done_nxt  = r_gnt;
         end
         S_DONE: begin
            w_state_nxt = S_IDLE;
            w_gnt_nxt   = '0;
`ifdef TOGGLE_BANK_ARBITER_RR_EN
            w_ptr_nxt   = (int'(r_idx) == NREQ - 1) ? '0 : r_idx + 1'b1;
`endif
         end
         default: begin
            w_state_nxt = S_IDLE;
            w_gnt_nxt   = '0;
         end
      endcase
   end

   // ------------------------------------------------------------------------
   // Datapath registers
   // ------------------------------------------------------------------------
   always_ff @(posedge Clk or negedge rst) begin
      if (!rst) begin
         r_gnt  <= '0;
         r_done <= '0;
         r_q    <= '0;
         r_mask <= '0;
`ifdef TOGGLE_BANK_ARBITER_RR_EN
         r_ptr  <= '0;
         r_idx  <= '0;
`endif
      end else begin
         r_gnt  <= w_gnt_nxt;
         r_done <= w_done_nxt;
         r_q    <= w_q_nxt;
         r_mask <= w_mask_nxt;
`ifdef TOGGLE_BANK_ARBITER_RR_EN
         r_ptr  <= w_ptr_nxt;
         r_idx  <= w_idx_nxt;
`endif
      end
   end

   assign gnt  = r_gnt;
   assign done = r_done;
   assign Q    = r_q;
   assign Q_b  = ~r_q;
   assign busy = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: doc/toggle_bank_arbiter.md
TOGGLE_BANK_ARBITER -- requirements
Module: toggle_bank_arbiter

Interface
REQ-001 SHALL have parameter NREQ, default 4, number of requesters (2..8).
REQ-002 SHALL have parameter WIDTH, default 8, number of toggle flip-flops in the shared bank.
REQ-003 SHALL have port Clk  input  1  rising-edge clock.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port req  input  NREQ  per-requester toggle request, level, held until done.
REQ-006 SHALL have port mask  input  NREQ*WIDTH  per-requester toggle mask; slice i = mask[i*WIDTH +: WIDTH].
REQ-007 SHALL have port gnt  output  NREQ  one-hot grant, held for the whole transaction.
REQ-008 SHALL have port done  output  NREQ  one-cycle completion pulse to the granted requester.
REQ-009 SHALL have port Q  output  WIDTH  toggle bank state.
REQ-010 SHALL have port Q_b  output  WIDTH  bitwise complement of Q, combinational.
REQ-011 SHALL have port busy  output  1  high in any state other than IDLE.

Function
REQ-012 SHALL implement FSM states IDLE, TOGGLE and DONE, each lasting exactly one cycle except IDLE.
REQ-013 IDLE: if any req bit is high, SHALL select one winner, latch its index and mask slice, assert gnt[winner], and go to TOGGLE; otherwise stay in IDLE.
REQ-014 TOGGLE: SHALL update Q <= Q ^ latched_mask (T=1 bits invert, T=0 bits hold), keep gnt, and go to DONE.
REQ-015 DONE: SHALL pulse done[winner] for one cycle, keep gnt, advance the arbitration pointer, and go to IDLE with gnt cleared on exit.
REQ-016 Latency SHALL be: req high at edge n (in IDLE) -> gnt from n+1 -> Q updated and done high from n+2 -> gnt and done low from n+3.
REQ-017 A requester SHALL drop req on the edge at which it samples done high; req still high in the next IDLE is a new request.
REQ-018 mask SHALL be sampled only on the IDLE->TOGGLE edge; changes during TOGGLE or DONE SHALL be ignored.
REQ-019 A req withdrawn while granted SHALL NOT abort the transaction; TOGGLE and DONE complete normally.
REQ-020 An all-zero latched mask SHALL complete the full handshake with Q unchanged.
REQ-021 At most one gnt bit and one done bit SHALL be high in any cycle, and done SHALL only be high when the matching gnt bit is high.
REQ-022 Requests arriving while busy SHALL wait without loss; they are arbitrated in the next IDLE.
REQ-023 Back-to-back transactions SHALL sustain one toggle per 3 cycles.

Reset
REQ-024 When rst is low, SHALL asynchronously force state=IDLE, Q=0 (Q_b all ones), gnt=0, done=0, busy=0, pointer=0, and latched mask=0.
REQ-025 Reset asserted during TOGGLE or DONE SHALL discard the transaction with no done pulse; the first edge after rst release SHALL be evaluated from IDLE.

Configuration
REQ-026 SHALL honour macro TOGGLE_BANK_ARBITER_RR_EN.
- Defined: round-robin arbitration; search starts at the pointer, and after DONE the pointer becomes (winner+1) mod NREQ.
- Undefined: fixed priority, lowest index wins, and the pointer is unused (constant 0).

Verification
REQ-027 Reset check: rst=0 mid-TOGGLE with Q=8'h0F -> Q=8'h00 and Q_b=8'hFF immediately, no done pulse, state IDLE.
REQ-028 Single transaction: req=4'b0010, mask slice1=8'hA5 from Q=8'h00 -> gnt=4'b0010 at n+1, Q=8'hA5 and done=4'b0010 at n+2, gnt=0 at n+3.
REQ-029 Double toggle: two transactions by requester 0 with mask 8'h3C each -> Q goes 8'h00 -> 8'h3C -> 8'h00.
REQ-030 Contention with RR_EN defined: req=4'b1111 held, each requester drops req after its done -> grant order 0,1,2,3; with RR_EN undefined and req=4'b1111 re-raised each time -> requester 0 is always granted.
REQ-031 Mask hold: change mask slice 2 from 8'h01 to 8'hFF during TOGGLE -> Q ^= 8'h01 only.
REQ-032 Zero mask / withdrawal: req[3] with mask 8'h00, dropped during TOGGLE -> done[3] still pulses at n+2 and Q is unchanged.
